// File: rtl/pcpu_run_ctrl_pkg.sv
// pcpu_run_ctrl_pkg: shared opcodes, state encodings and PCPU select codes for the run controller
package pcpu_run_ctrl_pkg;
  localparam logic [4:0] HALT_OP_DEF = 5'b00001;
  localparam int STEP_W_DEF = 16;
  localparam logic [3:0] SEL_WB_IR = 4'd4;
  typedef enum logic [2:0] {
    OP_STATUS, OP_WR_IMEM, OP_WR_DMEM, OP_RD_DMEM, OP_RD_GR, OP_RUN, OP_STEP, OP_STOP
  } cmd_op_e;
  typedef enum logic [3:0] {
    S_RST0, S_RST1, S_IDLE, S_WRITE, S_RD1, S_RD2, S_GR, S_GO, S_RUN, S_STEP
  } state_e;
  function automatic logic [15:0] status_word(input logic halted, input logic running, input logic [7:0] pc);
    return {halted, running, 6'b0, pc};
  endfunction
endpackage

// File: rtl/pcpu_mem_mux.sv
// pcpu_mem_mux: hands the imem/dmem ports to the CPU while it runs, to the controller otherwise
module pcpu_mem_mux (
  input  logic        cpu_own,
  input  logic [7:0]  ctl_addr,
  input  logic [15:0] ctl_wdata,
  input  logic        ctl_imem_we,
  input  logic        ctl_dmem_we,
  input  logic [7:0]  cpu_i_addr,
  input  logic [7:0]  cpu_d_addr,
  input  logic [15:0] cpu_d_dout,
  input  logic        cpu_d_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        imem_we,
  output logic [7:0]  dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we
);
  assign imem_addr  = cpu_own ? cpu_i_addr : ctl_addr;
  assign imem_wdata = ctl_wdata;
  assign imem_we    = !cpu_own && ctl_imem_we;
  assign dmem_addr  = cpu_own ? cpu_d_addr : ctl_addr;
  assign dmem_wdata = cpu_own ? cpu_d_dout : ctl_wdata;
  assign dmem_we    = cpu_own ? cpu_d_we : ctl_dmem_we;
endmodule

// File: rtl/pcpu_run_ctrl.sv
// pcpu_run_ctrl: host command sequencer that loads, runs, steps, stops and inspects the PCPU
module pcpu_run_ctrl
  import pcpu_run_ctrl_pkg::*;
#(
  parameter logic [4:0] HALT_OP = HALT_OP_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        cpu_reset,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic        cpu_show_gr,
  output logic [3:0]  cpu_select_y,
  input  logic [15:0] cpu_y,
  input  logic [7:0]  cpu_i_addr,
  input  logic [7:0]  cpu_d_addr,
  input  logic [15:0] cpu_d_dout,
  input  logic        cpu_d_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        imem_we,
  output logic [7:0]  dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [15:0] dmem_rdata
);
  state_e state, nxt;
  cmd_op_e op_q, op_in;
  logic [7:0] addr_q, last_pc;
  logic [15:0] data_q, rsp_d_n;
  logic [STEP_W-1:0] step_cnt;
  logic halted, stop_pend, acc, running, halt_hit, step_end, rsp_v_n, rsp_e_n;
  logic ctl_imem_we, ctl_dmem_we;
  assign op_in    = cmd_op_e'(cmd_op);
  assign acc      = cmd_valid && cmd_ready;
  assign running  = state inside {S_GO, S_RUN, S_STEP};
  assign halt_hit = (state == S_RUN || state == S_STEP) && cpu_y[15:11] == HALT_OP;
  assign step_end = state == S_STEP && step_cnt == STEP_W'(1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= S_RST0;
      op_q      <= OP_STATUS;
      addr_q    <= '0;
      data_q    <= '0;
      step_cnt  <= '0;
      halted    <= 1'b0;
      stop_pend <= 1'b0;
      last_pc   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= nxt;
      rsp_valid <= rsp_v_n;
      rsp_data  <= rsp_d_n;
      rsp_err   <= rsp_e_n;
      if (running) last_pc <= cpu_i_addr;
      if (state == S_STEP) step_cnt <= step_cnt - STEP_W'(1);
      if (halt_hit) halted <= 1'b1;
      if (state == S_RST1) stop_pend <= 1'b0;
      if (acc && state == S_IDLE) begin
        op_q   <= op_in;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        if (op_in == OP_RUN || op_in == OP_STOP || (op_in == OP_STEP && cmd_data != '0)) halted <= 1'b0;
        if (op_in == OP_RUN) step_cnt <= '0;
        if (op_in == OP_STEP) step_cnt <= STEP_W'(cmd_data);
        if (op_in == OP_STOP) stop_pend <= 1'b1;
      end
    end
  // A run ends on halt, step exhaustion or STOP; halt takes precedence in the reported flags
  always_comb begin
    nxt     = state;
    rsp_v_n = 1'b0;
    rsp_e_n = 1'b0;
    rsp_d_n = '0;
    case (state)
      S_RST0: nxt = S_RST1;
      S_RST1: begin
        nxt     = S_IDLE;
        rsp_v_n = stop_pend;
        rsp_d_n = status_word(1'b0, 1'b0, last_pc);
      end
      S_IDLE:
        if (acc)
          case (op_in)
            OP_STATUS: begin
              rsp_v_n = 1'b1;
              rsp_d_n = status_word(halted, 1'b0, last_pc);
            end
            OP_WR_IMEM, OP_WR_DMEM: nxt = S_WRITE;
            OP_RD_DMEM: nxt = S_RD1;
            OP_RD_GR: nxt = S_GR;
            OP_RUN: nxt = S_GO;
            OP_STEP: begin
              nxt     = cmd_data == '0 ? S_IDLE : S_GO;
              rsp_v_n = cmd_data == '0;
              rsp_e_n = cmd_data == '0;
            end
            default: nxt = S_RST0;
          endcase
      S_WRITE: begin
        nxt     = S_IDLE;
        rsp_v_n = 1'b1;
        rsp_d_n = data_q;
      end
      S_RD1: nxt = S_RD2;
      S_RD2: begin
        nxt     = S_IDLE;
        rsp_v_n = 1'b1;
        rsp_d_n = dmem_rdata;
      end
      S_GR: begin
        nxt     = S_IDLE;
        rsp_v_n = 1'b1;
        rsp_d_n = cpu_y;
      end
      S_GO: nxt = step_cnt != '0 ? S_STEP : S_RUN;
      default:
        if (halt_hit || step_end || (acc && op_in == OP_STOP)) begin
          nxt     = S_IDLE;
          rsp_v_n = 1'b1;
          rsp_d_n = status_word(halt_hit, 1'b0, cpu_i_addr);
        end else if (acc) begin
          rsp_v_n = 1'b1;
          rsp_e_n = op_in != OP_STATUS;
          rsp_d_n = op_in == OP_STATUS ? status_word(halted, 1'b1, last_pc) : '0;
        end
    endcase
  end
  always_comb begin
    cmd_ready    = state == S_IDLE || state == S_RUN || state == S_STEP;
    cpu_reset    = state == S_RST0 || state == S_RST1;
    cpu_enable   = running;
    cpu_start    = state == S_GO;
    cpu_show_gr  = state == S_GR;
    cpu_select_y = state == S_GR ? {1'b0, addr_q[2:0]} : (state == S_RUN || state == S_STEP) ? SEL_WB_IR : 4'd0;
    ctl_imem_we  = state == S_WRITE && op_q == OP_WR_IMEM;
    ctl_dmem_we  = state == S_WRITE && op_q == OP_WR_DMEM;
  end
  pcpu_mem_mux u_mux (
    .cpu_own    (running),
    .ctl_addr   (addr_q),
    .ctl_wdata  (data_q),
    .ctl_imem_we(ctl_imem_we),
    .ctl_dmem_we(ctl_dmem_we),
    .cpu_i_addr (cpu_i_addr),
    .cpu_d_addr (cpu_d_addr),
    .cpu_d_dout (cpu_d_dout),
    .cpu_d_we   (cpu_d_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we)
  );
endmodule

// File: tb/tb_pcpu_run_ctrl.sv
// tb_pcpu_run_ctrl: table-driven and scoreboarded bench for the PCPU run controller
module tb_pcpu_run_ctrl;
  import pcpu_run_ctrl_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic rsp_valid, rsp_err, cpu_reset, cpu_enable, cpu_start, cpu_show_gr;
  logic [15:0] rsp_data, cpu_y, imem_wdata, dmem_wdata, dmem_rdata;
  logic [3:0] cpu_select_y;
  logic [7:0] imem_addr, dmem_addr;
  logic imem_we, dmem_we;
  logic [7:0] cpu_i_addr, cpu_d_addr;
  logic [15:0] cpu_d_dout;
  logic cpu_d_we;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] gr [8];
  logic [15:0] wb_ir = '0;
  assign cpu_i_addr = 8'h2A;
  assign cpu_d_addr = 8'h40;
  assign cpu_d_dout = 16'h7777;
  assign cpu_d_we   = 1'b1;
  assign cpu_y = cpu_show_gr ? gr[cpu_select_y[2:0]] : (cpu_select_y == 4'd4 ? wb_ir : 16'h0);
  always #5 clock = ~clock;
  pcpu_run_ctrl dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .cpu_show_gr(cpu_show_gr), .cpu_select_y(cpu_select_y), .cpu_y(cpu_y),
    .cpu_i_addr(cpu_i_addr), .cpu_d_addr(cpu_d_addr), .cpu_d_dout(cpu_d_dout), .cpu_d_we(cpu_d_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
  );
  always @(posedge clock)
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        imem[i] <= '0;
        dmem[i] <= '0;
      end
      dmem_rdata <= '0;
    end else begin
      if (imem_we) imem[imem_addr] <= imem_wdata;
      if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
      dmem_rdata <= dmem[dmem_addr];
    end
  typedef struct {logic [15:0] d; logic e; int lat; int acc;} exp_t;
  typedef struct {logic [2:0] op; logic [7:0] a; logic [15:0] d; logic [15:0] ed; logic ee; int lat;} vec_t;
  exp_t sb [$];
  exp_t mx;
  vec_t tbl [10];
  int checks = 0, errors = 0, cyc = 0, rsp_cnt = 0, en_cnt = 0, st_cnt = 0, iw_cnt = 0;
  int e0, s0, r0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (cpu_enable) en_cnt++;
    if (cpu_start) st_cnt++;
    if (imem_we) iw_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        mx = sb.pop_front();
        chk("rsp_data", {16'h0, rsp_data}, {16'h0, mx.d});
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, mx.e});
        if (mx.lat != 0) chk("rsp_latency", cyc - mx.acc, mx.lat);
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [15:0] d,
                      input bit exp_rsp, input logic [15:0] ed, input logic ee, input int lat);
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    if (exp_rsp) sb.push_back('{ed, ee, lat, cyc - 1});
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_drain_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8; i++) gr[i] = 16'h1000 + 16'(i);
    gr[5] = 16'hA5A5;
    tbl[0] = '{OP_WR_IMEM, 8'h05, 16'h1234, 16'h1234, 1'b0, 2};
    tbl[1] = '{OP_WR_DMEM, 8'h10, 16'hBEEF, 16'hBEEF, 1'b0, 2};
    tbl[2] = '{OP_RD_DMEM, 8'h10, 16'h0000, 16'hBEEF, 1'b0, 3};
    tbl[3] = '{OP_WR_DMEM, 8'h11, 16'h0055, 16'h0055, 1'b0, 2};
    tbl[4] = '{OP_RD_DMEM, 8'h11, 16'h0000, 16'h0055, 1'b0, 3};
    tbl[5] = '{OP_STATUS,  8'h00, 16'h0000, 16'h0000, 1'b0, 1};
    tbl[6] = '{OP_STEP,    8'h00, 16'h0000, 16'h0000, 1'b1, 1};
    tbl[7] = '{OP_STOP,    8'h00, 16'h0000, 16'h0000, 1'b0, 3};
    tbl[8] = '{OP_RD_DMEM, 8'h40, 16'h0000, 16'h0000, 1'b0, 3};
    tbl[9] = '{OP_RD_GR,   8'h05, 16'h0000, 16'hA5A5, 1'b0, 2};
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    chk("rst_cpu_ctl", {24'h0, cpu_enable, cpu_start, cpu_show_gr, cpu_select_y, rsp_err}, 32'd0);
    chk("rst_mem_we", {30'h0, imem_we, dmem_we}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].d, 1'b1, tbl[i].ed, tbl[i].ee, tbl[i].lat);
      drain();
    end
    chk("imem_5", {16'h0, imem[5]}, 32'h1234);
    chk("imem_we_pulses", iw_cnt, 32'd1);
    // program load, run to halt, read back the result register
    gr[1] = 16'h0003;
    send(OP_WR_IMEM, 8'h00, 16'h5803, 1'b1, 16'h5803, 1'b0, 2);
    send(OP_WR_IMEM, 8'h01, 16'h0800, 1'b1, 16'h0800, 1'b0, 2);
    drain();
    s0 = st_cnt;
    send(OP_RUN, 8'h00, 16'h0000, 1'b1, 16'h802A, 1'b0, 0);
    repeat (5) @(negedge clock);
    chk("run_enable", {31'h0, cpu_enable}, 32'd1);
    chk("run_select_y", {28'h0, cpu_select_y}, 32'd4);
    wb_ir = 16'h0800;
    drain();
    wb_ir = 16'h0000;
    chk("halt_enable_off", {31'h0, cpu_enable}, 32'd0);
    chk("run_start_pulses", st_cnt - s0, 32'd1);
    chk("cpu_dmem_write", {16'h0, dmem[8'h40]}, 32'h7777);
    send(OP_STATUS, 8'h00, 16'h0000, 1'b1, 16'h802A, 1'b0, 1);
    send(OP_RD_GR, 8'h01, 16'h0000, 1'b1, 16'h0003, 1'b0, 2);
    drain();
    // single-step counts
    e0 = en_cnt;
    send(OP_STEP, 8'h00, 16'd4, 1'b1, 16'h002A, 1'b0, 6);
    drain();
    chk("step4_enable_cycles", en_cnt - e0, 32'd5);
    e0 = en_cnt;
    send(OP_STEP, 8'h00, 16'd1, 1'b1, 16'h002A, 1'b0, 3);
    drain();
    chk("step1_enable_cycles", en_cnt - e0, 32'd2);
    e0 = en_cnt;
    send(OP_STEP, 8'h00, 16'd0, 1'b1, 16'h0000, 1'b1, 1);
    drain();
    chk("step0_no_cycles", en_cnt - e0, 32'd0);
    // commands while running
    send(OP_RUN, 8'h00, 16'h0000, 1'b0, 16'h0, 1'b0, 0);
    repeat (3) @(negedge clock);
    send(OP_WR_DMEM, 8'h30, 16'h1111, 1'b1, 16'h0000, 1'b1, 1);
    send(OP_WR_IMEM, 8'h07, 16'h2222, 1'b1, 16'h0000, 1'b1, 1);
    send(OP_STATUS, 8'h00, 16'h0000, 1'b1, 16'h402A, 1'b0, 1);
    send(OP_STOP, 8'h00, 16'h0000, 1'b1, 16'h002A, 1'b0, 1);
    drain();
    chk("stop_enable_off", {31'h0, cpu_enable}, 32'd0);
    chk("stop_idle_ready", {31'h0, cmd_ready}, 32'd1);
    chk("stop_no_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    chk("run_wr_dmem_blocked", {16'h0, dmem[8'h30]}, 32'd0);
    chk("run_wr_imem_blocked", {16'h0, imem[7]}, 32'd0);
    send(OP_STATUS, 8'h00, 16'h0000, 1'b1, 16'h002A, 1'b0, 1);
    drain();
    // async reset during a read drops the response
    send(OP_RD_DMEM, 8'h10, 16'h0000, 1'b0, 16'h0, 1'b0, 0);
    reset = 1'b1;
    r0 = rsp_cnt;
    #2;
    chk("areset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("areset_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    chk("areset_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rel_cpu_reset_c0", {31'h0, cpu_reset}, 32'd1);
    @(negedge clock);
    chk("rel_cpu_reset_c1", {31'h0, cpu_reset}, 32'd1);
    @(negedge clock);
    chk("rel_cpu_reset_c2", {31'h0, cpu_reset}, 32'd0);
    chk("rel_idle_ready", {31'h0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clock);
    chk("areset_rsp_dropped", rsp_cnt - r0, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
